// File: rtl/rheed_pkg.sv
// rtl/rheed_pkg.sv - shared types and helpers for the RHEED crop stream front end
package rheed_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam int POS_W = 16;
    typedef logic [POS_W-1:0] pos_t;

    function automatic pos_t clamp_origin(input pos_t origin, input pos_t max_origin);
        return (origin > max_origin) ? max_origin : origin;
    endfunction

    function automatic logic lane_in_window(
        input pos_t col,
        input pos_t row,
        input pos_t x0,
        input pos_t y0,
        input pos_t ncols,
        input pos_t nrows
    );
        return (col >= x0) && (col < pos_t'(x0 + ncols)) &&
               (row >= y0) && (row < pos_t'(y0 + nrows));
    endfunction

endpackage

// File: rtl/rheed_beat_unpacker.sv
// rtl/rheed_beat_unpacker.sv - holds one wide input beat and walks its lanes; discards beats that miss the crop window
module rheed_beat_unpacker
    import rheed_pkg::*;
#(
    parameter int PIX_W           = 8,
    parameter int PIXELS_PER_BEAT = 32,
    parameter int OUT_ROWS        = 20,
    parameter int OUT_COLS        = 20,
    localparam int DATA_W         = PIXELS_PER_BEAT*PIX_W,
    localparam int LW             = (PIXELS_PER_BEAT > 1) ? $clog2(PIXELS_PER_BEAT) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    input  logic [DATA_W-1:0] s_axis_tdata,
    input  pos_t              base_col,
    input  pos_t              base_row,
    input  pos_t              x0e,
    input  pos_t              y0e,
    input  logic              lane_adv,
    output logic              lane_valid,
    output logic [PIX_W-1:0]  lane_pix,
    output logic              skip_accept
);

    localparam pos_t OC    = pos_t'(OUT_COLS);
    localparam pos_t ORW   = pos_t'(OUT_ROWS);
    localparam pos_t PPB_P = pos_t'(PIXELS_PER_BEAT);

    logic [DATA_W-1:0] beat;
    logic [LW-1:0]     lane;
    logic              full;
    logic              last_lane;
    logic              accept;
    logic              beat_hits;

    assign last_lane     = (lane == LW'(PIXELS_PER_BEAT-1));
    assign s_axis_tready = run && (!full || (lane_adv && last_lane));
    assign accept        = s_axis_tvalid && s_axis_tready;

    // base_col/base_row is the position of lane 0 of the beat being offered
    assign beat_hits = (base_row >= y0e) && (base_row < pos_t'(y0e + ORW)) &&
                       (base_col < pos_t'(x0e + OC)) && (pos_t'(base_col + PPB_P) > x0e);
    assign skip_accept = accept && !beat_hits;

    assign lane_valid = full;
    assign lane_pix   = beat[int'(lane)*PIX_W +: PIX_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat <= '0;
            lane <= '0;
            full <= 1'b0;
        end else if (accept) begin
            beat <= s_axis_tdata;
            lane <= '0;
            full <= beat_hits;
        end else if (lane_adv) begin
            lane <= lane + LW'(1);
            if (last_lane) begin
                full <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/rheed_crop_stream.sv
// rtl/rheed_crop_stream.sv - unpack wide beats, crop a window, emit one pixel per transfer with SOF/EOF
// Optional normaliser enabled by defining RHEED_CROP_NORM_EN.
module rheed_crop_stream
    import rheed_pkg::*;
#(
    parameter int IN_ROWS         = 20,
    parameter int IN_COLS         = 20,
    parameter int OUT_ROWS        = 20,
    parameter int OUT_COLS        = 20,
    parameter int PIX_W           = 8,
    parameter int PIXELS_PER_BEAT = 32,
    localparam int DATA_W         = PIXELS_PER_BEAT*PIX_W
) (
    input  logic                       clk,
    input  logic                       ap_rst_n,
    input  logic                       ap_start,
    output logic                       ap_ready,
    output logic                       ap_done,
    input  logic [$clog2(IN_COLS)-1:0] crop_x0,
    input  logic [$clog2(IN_ROWS)-1:0] crop_y0,
    input  logic [PIX_W-1:0]           norm_offset,
    input  logic [2:0]                 norm_shift,
    input  logic                       s_axis_tvalid,
    output logic                       s_axis_tready,
    input  logic [DATA_W-1:0]          s_axis_tdata,
    output logic                       m_axis_tvalid,
    input  logic                       m_axis_tready,
    output logic [PIX_W-1:0]           m_axis_tdata,
    output logic                       m_axis_tuser,
    output logic                       m_axis_tlast
);

    localparam pos_t COL_MAX   = pos_t'(IN_COLS-1);
    localparam pos_t ROW_MAX   = pos_t'(IN_ROWS-1);
    localparam pos_t X0_MAX    = pos_t'(IN_COLS-OUT_COLS);
    localparam pos_t Y0_MAX    = pos_t'(IN_ROWS-OUT_ROWS);
    localparam pos_t OC        = pos_t'(OUT_COLS);
    localparam pos_t ORW       = pos_t'(OUT_ROWS);
    localparam pos_t PPB_P     = pos_t'(PIXELS_PER_BEAT);
    localparam pos_t LAST_BASE = pos_t'(IN_COLS-PIXELS_PER_BEAT);

    state_t           state;
    pos_t             col_cnt, row_cnt;
    pos_t             x0e, y0e;
    pos_t             nxt_col, nxt_row;
    pos_t             base_col, base_row;
    pos_t             skip_col, skip_row;
    pos_t             x_last, y_last;
    logic             lane_valid;
    logic [PIX_W-1:0] lane_pix;
    logic [PIX_W-1:0] pix_out;
    logic             skip_accept;
    logic             in_win;
    logic             stall;
    logic             lane_adv;
    logic             load;
    logic             at_last;
    logic             last_pix;

    always_comb begin
        nxt_col = (col_cnt == COL_MAX) ? '0 : pos_t'(col_cnt + pos_t'(1));
        nxt_row = (col_cnt == COL_MAX) ? pos_t'(row_cnt + pos_t'(1)) : row_cnt;
        // A beat accepted while the last lane drains starts at the position after that lane
        base_col = lane_valid ? nxt_col : col_cnt;
        base_row = lane_valid ? nxt_row : row_cnt;
        skip_col = (base_col == LAST_BASE) ? '0 : pos_t'(base_col + PPB_P);
        skip_row = (base_col == LAST_BASE) ? pos_t'(base_row + pos_t'(1)) : base_row;
        x_last   = pos_t'(x0e + OC - pos_t'(1));
        y_last   = pos_t'(y0e + ORW - pos_t'(1));
    end

    assign in_win   = lane_in_window(col_cnt, row_cnt, x0e, y0e, OC, ORW);
    assign stall    = in_win && m_axis_tvalid && !m_axis_tready;
    assign lane_adv = (state == RUN) && lane_valid && !stall;
    assign load     = lane_adv && in_win;
    assign at_last  = (col_cnt == COL_MAX) && (row_cnt == ROW_MAX);
    assign last_pix = (lane_adv && at_last) ||
                      (skip_accept && (base_col == LAST_BASE) && (base_row == ROW_MAX));

    rheed_beat_unpacker #(
        .PIX_W          (PIX_W),
        .PIXELS_PER_BEAT(PIXELS_PER_BEAT),
        .OUT_ROWS       (OUT_ROWS),
        .OUT_COLS       (OUT_COLS)
    ) u_unpacker (
        .clk          (clk),
        .rst_n        (ap_rst_n),
        .run          ((state == RUN) && !at_last),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready),
        .s_axis_tdata (s_axis_tdata),
        .base_col     (base_col),
        .base_row     (base_row),
        .x0e          (x0e),
        .y0e          (y0e),
        .lane_adv     (lane_adv),
        .lane_valid   (lane_valid),
        .lane_pix     (lane_pix),
        .skip_accept  (skip_accept)
    );

`ifdef RHEED_CROP_NORM_EN
    localparam int NW = PIX_W + 8;
    logic [PIX_W-1:0] off_q;
    logic [2:0]       shift_q;
    logic [NW-1:0]    norm_diff;
    logic [NW-1:0]    norm_shl;

    always_comb begin
        norm_diff = (lane_pix > off_q) ? {8'b0, lane_pix - off_q} : '0;
        norm_shl  = norm_diff << shift_q;
        pix_out   = (|norm_shl[NW-1:PIX_W]) ? '1 : norm_shl[PIX_W-1:0];
    end

    always_ff @(posedge clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            off_q   <= '0;
            shift_q <= '0;
        end else if (state == IDLE && ap_start) begin
            off_q   <= norm_offset;
            shift_q <= norm_shift;
        end
    end
`else
    logic unused_norm;
    assign unused_norm = ^{norm_offset, norm_shift};
    assign pix_out     = lane_pix;
`endif

    always_ff @(posedge clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state         <= IDLE;
            col_cnt       <= '0;
            row_cnt       <= '0;
            x0e           <= '0;
            y0e           <= '0;
            ap_ready      <= 1'b1;
            ap_done       <= 1'b0;
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tuser  <= 1'b0;
            m_axis_tlast  <= 1'b0;
        end else begin
            ap_done <= 1'b0;

            if (load) begin
                m_axis_tvalid <= 1'b1;
                m_axis_tdata  <= pix_out;
                m_axis_tuser  <= (col_cnt == x0e) && (row_cnt == y0e);
                m_axis_tlast  <= (col_cnt == x_last) && (row_cnt == y_last);
            end else if (m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (ap_start) begin
                        x0e      <= clamp_origin(pos_t'(crop_x0), X0_MAX);
                        y0e      <= clamp_origin(pos_t'(crop_y0), Y0_MAX);
                        col_cnt  <= '0;
                        row_cnt  <= '0;
                        ap_ready <= 1'b0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    if (skip_accept) begin
                        col_cnt <= skip_col;
                        row_cnt <= skip_row;
                    end else if (lane_adv) begin
                        col_cnt <= nxt_col;
                        row_cnt <= nxt_row;
                    end
                    if (last_pix) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (!m_axis_tvalid) begin
                        ap_done  <= 1'b1;
                        ap_ready <= 1'b1;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rheed_crop_stream.sv
// tb/tb_rheed_crop_stream.sv - directed self-checking bench for rheed_crop_stream (8x8 in, 4x4 crop, 4 pixels per beat)
module tb_rheed_crop_stream;

    localparam int IN_ROWS  = 8;
    localparam int IN_COLS  = 8;
    localparam int OUT_ROWS = 4;
    localparam int OUT_COLS = 4;
    localparam int PIX_W    = 8;
    localparam int PPB      = 4;
    localparam int NBEATS   = IN_ROWS*IN_COLS/PPB;

    logic        clk = 1'b0;
    logic        ap_rst_n;
    logic        ap_start;
    logic        ap_ready;
    logic        ap_done;
    logic [2:0]  crop_x0;
    logic [2:0]  crop_y0;
    logic [7:0]  norm_offset;
    logic [2:0]  norm_shift;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic [31:0] s_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic [7:0]  m_axis_tdata;
    logic        m_axis_tuser;
    logic        m_axis_tlast;

    always #5 clk = ~clk;

    rheed_crop_stream #(
        .IN_ROWS(IN_ROWS), .IN_COLS(IN_COLS), .OUT_ROWS(OUT_ROWS), .OUT_COLS(OUT_COLS),
        .PIX_W(PIX_W), .PIXELS_PER_BEAT(PPB)
    ) dut (
        .clk(clk), .ap_rst_n(ap_rst_n), .ap_start(ap_start), .ap_ready(ap_ready), .ap_done(ap_done),
        .crop_x0(crop_x0), .crop_y0(crop_y0), .norm_offset(norm_offset), .norm_shift(norm_shift),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready), .s_axis_tdata(s_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready), .m_axis_tdata(m_axis_tdata),
        .m_axis_tuser(m_axis_tuser), .m_axis_tlast(m_axis_tlast)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0] got_data[$];
    bit         got_user[$];
    bit         got_last[$];
    int         done_cnt;
    int         stall_viol;
    int         first_valid_it;
    int         acc_it[NBEATS];
    bit         timed_out;

    function automatic logic [31:0] beat_data(input int b);
        logic [31:0] d;
        int row, c0;
        row = b / 2;
        c0  = (b % 2) * 4;
        for (int l = 0; l < PPB; l++) d[l*8 +: 8] = 8'(row*8 + c0 + l);
        return d;
    endfunction

    function automatic int win_pix(input int x0e, input int y0e, input int i);
        return (y0e + i/OUT_COLS)*IN_COLS + x0e + i%OUT_COLS;
    endfunction

    function automatic int norm_ref(input int p, input int off, input int sh);
`ifdef RHEED_CROP_NORM_EN
        int d;
        d = (p > off) ? p - off : 0;
        d = d << sh;
        return (d > 255) ? 255 : d;
`else
        return p;
`endif
    endfunction

    // Drives one frame: start, stream beats, collect outputs until ap_done or stop_after outputs
    task automatic run_frame(input int x0, input int y0, input bit rnd, input int pulse_at,
                             input int stop_after, input logic [7:0] off, input logic [2:0] sh);
        int  beat;
        bit  pend;
        bit  prev_stall;
        logic [7:0] prev_d;
        int  it;
        got_data.delete(); got_user.delete(); got_last.delete();
        done_cnt = 0; stall_viol = 0; first_valid_it = -1; timed_out = 0;
        for (int b = 0; b < NBEATS; b++) acc_it[b] = -1;
        beat = 0; pend = 0; prev_stall = 0; prev_d = '0;
        @(negedge clk);
        crop_x0 = 3'(x0); crop_y0 = 3'(y0); norm_offset = off; norm_shift = sh; ap_start = 1'b1;
        m_axis_tready = 1'b1;
        @(negedge clk);
        ap_start = 1'b0;
        for (it = 0; it < 800; it++) begin
            if (pend) begin beat++; pend = 0; end
            s_axis_tvalid = (beat < NBEATS);
            s_axis_tdata  = (beat < NBEATS) ? beat_data(beat) : 32'h0;
            m_axis_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            ap_start      = (it == pulse_at);
            crop_x0       = (it == pulse_at) ? 3'd0 : 3'(x0);
            #1;
            if (s_axis_tvalid && s_axis_tready) begin pend = 1; acc_it[beat] = it; end
            if (prev_stall && (m_axis_tvalid !== 1'b1 || m_axis_tdata !== prev_d)) stall_viol++;
            prev_stall = (m_axis_tvalid === 1'b1) && !m_axis_tready;
            prev_d     = m_axis_tdata;
            if (m_axis_tvalid === 1'b1 && first_valid_it < 0) first_valid_it = it;
            if (m_axis_tvalid === 1'b1 && m_axis_tready) begin
                got_data.push_back(m_axis_tdata);
                got_user.push_back(m_axis_tuser);
                got_last.push_back(m_axis_tlast);
            end
            if (ap_done === 1'b1) done_cnt++;
            if (ap_done === 1'b1) break;
            if (stop_after > 0 && got_data.size() >= stop_after) break;
            @(negedge clk);
        end
        timed_out     = (it >= 800);
        s_axis_tvalid = 1'b0;
        ap_start      = 1'b0;
        m_axis_tready = 1'b1;
    endtask

    task automatic test_reset();
        ap_rst_n = 1'b0; ap_start = 1'b0; crop_x0 = '0; crop_y0 = '0;
        norm_offset = '0; norm_shift = '0; s_axis_tvalid = 1'b0; s_axis_tdata = '0; m_axis_tready = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({ap_ready, ap_done, s_axis_tready, m_axis_tvalid, m_axis_tuser, m_axis_tlast} !== 6'b100000) begin
            errors++;
            $display("FAIL reset_ctrl: got ready/done/sready/mvalid/user/last=%b want 100000",
                     {ap_ready, ap_done, s_axis_tready, m_axis_tvalid, m_axis_tuser, m_axis_tlast});
        end
        checks++;
        if (m_axis_tdata !== 8'd0) begin
            errors++; $display("FAIL reset_tdata: got %0d want 0", m_axis_tdata);
        end
        ap_rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (ap_ready !== 1'b1 || s_axis_tready !== 1'b0) begin
            errors++; $display("FAIL idle_after_reset: got ready=%b sready=%b want 1 0", ap_ready, s_axis_tready);
        end
    endtask

    task automatic test_crop_basic();
        run_frame(2, 3, 0, -1, 0, 8'd0, 3'd0);
        checks++;
        if (timed_out) begin errors++; $display("FAIL basic_timeout: no ap_done within budget"); end
        checks++;
        if (got_data.size() !== 16) begin
            errors++; $display("FAIL basic_count: got %0d want 16", got_data.size());
        end
        for (int i = 0; i < 16 && i < got_data.size(); i++) begin
            checks++;
            if (got_data[i] !== 8'(win_pix(2, 3, i)) || got_user[i] !== (i == 0) || got_last[i] !== (i == 15)) begin
                errors++;
                $display("FAIL basic_pix[%0d]: got %0d/u%0d/l%0d want %0d/u%0d/l%0d", i, got_data[i],
                         got_user[i], got_last[i], win_pix(2, 3, i), (i == 0), (i == 15));
            end
        end
        checks++;
        if (got_data.size() > 0 && (got_data[0] !== 8'd26 || got_data[got_data.size()-1] !== 8'd53)) begin
            errors++; $display("FAIL basic_ends: got %0d..%0d want 26..53", got_data[0], got_data[got_data.size()-1]);
        end
        checks++;
        if (first_valid_it - acc_it[6] !== 4) begin
            errors++; $display("FAIL basic_latency: got %0d want 4", first_valid_it - acc_it[6]);
        end
        @(negedge clk);
        checks++;
        if (ap_done !== 1'b0 || done_cnt !== 1 || ap_ready !== 1'b1) begin
            errors++; $display("FAIL basic_done: got done=%b cnt=%0d ready=%b want 0 1 1", ap_done, done_cnt, ap_ready);
        end
    endtask

    task automatic test_clamp();
        run_frame(6, 7, 0, -1, 0, 8'd0, 3'd0);
        checks++;
        if (timed_out || got_data.size() !== 16) begin
            errors++; $display("FAIL clamp_count: got %0d timeout=%0d want 16 0", got_data.size(), timed_out);
        end
        for (int i = 0; i < 16 && i < got_data.size(); i++) begin
            checks++;
            if (got_data[i] !== 8'(win_pix(4, 4, i)) || got_user[i] !== (i == 0) || got_last[i] !== (i == 15)) begin
                errors++;
                $display("FAIL clamp_pix[%0d]: got %0d/u%0d/l%0d want %0d", i, got_data[i], got_user[i],
                         got_last[i], win_pix(4, 4, i));
            end
        end
        checks++;
        if (got_data.size() > 0 && (got_data[0] !== 8'd36 || got_data[got_data.size()-1] !== 8'd63)) begin
            errors++; $display("FAIL clamp_ends: got %0d..%0d want 36..63", got_data[0], got_data[got_data.size()-1]);
        end
    endtask

    task automatic test_back_pressure();
        run_frame(2, 3, 1, -1, 0, 8'd0, 3'd0);
        checks++;
        if (timed_out || got_data.size() !== 16 || done_cnt !== 1) begin
            errors++; $display("FAIL bp_count: got %0d done=%0d timeout=%0d want 16 1 0", got_data.size(), done_cnt, timed_out);
        end
        checks++;
        if (stall_viol !== 0) begin
            errors++; $display("FAIL bp_stable: got %0d unstable stall cycles want 0", stall_viol);
        end
        for (int i = 0; i < 16 && i < got_data.size(); i++) begin
            checks++;
            if (got_data[i] !== 8'(win_pix(2, 3, i)) || got_user[i] !== (i == 0) || got_last[i] !== (i == 15)) begin
                errors++; $display("FAIL bp_pix[%0d]: got %0d want %0d", i, got_data[i], win_pix(2, 3, i));
            end
        end
    endtask

    task automatic test_norm();
        run_frame(2, 3, 0, -1, 0, 8'd20, 3'd2);
        checks++;
        if (timed_out || got_data.size() !== 16) begin
            errors++; $display("FAIL norm_count: got %0d want 16", got_data.size());
        end
        for (int i = 0; i < 16 && i < got_data.size(); i++) begin
            checks++;
            if (got_data[i] !== 8'(norm_ref(win_pix(2, 3, i), 20, 2))) begin
                errors++; $display("FAIL norm_pix[%0d]: got %0d want %0d", i, got_data[i], norm_ref(win_pix(2, 3, i), 20, 2));
            end
        end
        checks++;
`ifdef RHEED_CROP_NORM_EN
        if (got_data.size() == 16 && (got_data[0] !== 8'd24 || got_data[15] !== 8'd132)) begin
            errors++; $display("FAIL norm_ends: got %0d..%0d want 24..132", got_data[0], got_data[15]);
        end
`else
        if (got_data.size() == 16 && (got_data[0] !== 8'd26 || got_data[15] !== 8'd53)) begin
            errors++; $display("FAIL norm_ends: got %0d..%0d want 26..53", got_data[0], got_data[15]);
        end
`endif
        run_frame(4, 4, 0, -1, 0, 8'd0, 3'd3);
        checks++;
        if (timed_out || got_data.size() !== 16) begin
            errors++; $display("FAIL sat_count: got %0d want 16", got_data.size());
        end
        for (int i = 0; i < 16 && i < got_data.size(); i++) begin
            checks++;
            if (got_data[i] !== 8'(norm_ref(win_pix(4, 4, i), 0, 3))) begin
                errors++; $display("FAIL sat_pix[%0d]: got %0d want %0d", i, got_data[i], norm_ref(win_pix(4, 4, i), 0, 3));
            end
        end
    endtask

    task automatic test_start_ignored();
        run_frame(2, 3, 0, 10, 0, 8'd0, 3'd0);
        checks++;
        if (timed_out || got_data.size() !== 16 || done_cnt !== 1) begin
            errors++; $display("FAIL restart_count: got %0d done=%0d want 16 1", got_data.size(), done_cnt);
        end
        for (int i = 0; i < 16 && i < got_data.size(); i++) begin
            checks++;
            if (got_data[i] !== 8'(win_pix(2, 3, i))) begin
                errors++; $display("FAIL restart_pix[%0d]: got %0d want %0d", i, got_data[i], win_pix(2, 3, i));
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        run_frame(2, 3, 0, -1, 5, 8'd0, 3'd0);
        checks++;
        if (got_data.size() !== 5) begin
            errors++; $display("FAIL midreset_pre: got %0d outputs want 5", got_data.size());
        end
        @(posedge clk);
        #1;
        ap_rst_n = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if ({ap_ready, ap_done, s_axis_tready, m_axis_tvalid, m_axis_tlast} !== 5'b10000) begin
            errors++;
            $display("FAIL midreset_outputs: got ready/done/sready/mvalid/last=%b want 10000",
                     {ap_ready, ap_done, s_axis_tready, m_axis_tvalid, m_axis_tlast});
        end
        @(negedge clk);
        ap_rst_n = 1'b1;
        run_frame(2, 3, 0, -1, 0, 8'd0, 3'd0);
        checks++;
        if (timed_out || got_data.size() !== 16 || done_cnt !== 1) begin
            errors++; $display("FAIL midreset_frame: got %0d done=%0d want 16 1", got_data.size(), done_cnt);
        end
        for (int i = 0; i < 16 && i < got_data.size(); i++) begin
            checks++;
            if (got_data[i] !== 8'(win_pix(2, 3, i)) || got_user[i] !== (i == 0) || got_last[i] !== (i == 15)) begin
                errors++; $display("FAIL midreset_pix[%0d]: got %0d want %0d", i, got_data[i], win_pix(2, 3, i));
            end
        end
    endtask

    initial begin
        test_reset();
        test_crop_basic();
        test_clamp();
        test_back_pressure();
        test_norm();
        test_start_ignored();
        test_reset_mid_frame();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
